// File: rtl/fu_pkg.sv
// rtl/fu_pkg.sv - shared types and helpers for the scoreboard forwarding unit
package fu_pkg;

  localparam int FU_REG_W = 5;
  localparam int FU_LAT_W = 2;

  typedef struct packed {
    logic                valid;
    logic                wen;
    logic [FU_REG_W-1:0] dest;
    logic [FU_LAT_W-1:0] rdy_cnt;
  } sb_entry_t;

  typedef enum logic [FU_LAT_W-1:0] {
    LAT_ALU  = FU_LAT_W'(1),
    LAT_LOAD = FU_LAT_W'(2),
    LAT_MUL  = FU_LAT_W'(3)
  } lat_class_t;

  // Select width: value 0 means regfile, 1..nstages name a scoreboard position.
  function automatic int sel_w(input int nstages);
    return (nstages < 1) ? 1 : $clog2(nstages + 1);
  endfunction

  function automatic sb_entry_t sb_age(input sb_entry_t e);
    sb_entry_t r;
    r = e;
    if (r.rdy_cnt != '0) r.rdy_cnt = r.rdy_cnt - 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/fu_src_match.sv
// rtl/fu_src_match.sv - youngest-producer scan for one decode source operand
module fu_src_match
  import fu_pkg::*;
#(
  parameter int NSTAGES = 3,
  parameter int REG_W   = FU_REG_W,
  parameter int SEL_W   = sel_w(NSTAGES),
  parameter int FWD_EN  = 1
) (
  input  sb_entry_t [NSTAGES:1] sb,
  input  logic [REG_W-1:0]      src,
  input  logic                  ren,
  output logic [SEL_W-1:0]      sel,
  output logic                  hazard
);

  logic found;

  // Position 1 is scanned first, so the youngest matching producer wins.
  always_comb begin
    sel    = '0;
    hazard = 1'b0;
    found  = 1'b0;
    for (int i = 1; i <= NSTAGES; i++) begin
      if (!found && ren && (src != '0) && sb[i].valid && sb[i].wen &&
          (sb[i].dest == src)) begin
        found = 1'b1;
        if ((FWD_EN != 0) && (sb[i].rdy_cnt == '0)) sel = SEL_W'(i);
        else hazard = 1'b1;
      end
    end
  end

endmodule

// File: rtl/scoreboard_forward_unit.sv
// rtl/scoreboard_forward_unit.sv - in-flight destination scoreboard with operand forwarding and decode stall
module scoreboard_forward_unit
  import fu_pkg::*;
#(
  parameter int NSTAGES = 3,
  parameter int NSRC    = 2,
  parameter int REG_W   = FU_REG_W,
  parameter int LAT_W   = FU_LAT_W,
  parameter int FWD_EN  = 1,
  parameter int FLUSH_N = 1,
  parameter int CNT_W   = 16
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             pipe_en,
  input  logic                             flush,
  input  logic                             dec_valid,
  input  logic                             dec_wen,
  input  logic [REG_W-1:0]                 dec_dest,
  input  logic [LAT_W-1:0]                 dec_lat,
  input  logic [NSRC*REG_W-1:0]            src_reg,
  input  logic [NSRC-1:0]                  src_ren,
  output logic [NSRC*sel_w(NSTAGES)-1:0]   fwd_sel,
  output logic                             stall_dec,
  output logic [NSRC-1:0]                  hazard_src,
  output logic [CNT_W-1:0]                 stall_cycles
);

  localparam int SEL_W = sel_w(NSTAGES);

  sb_entry_t [NSTAGES:1] sb;
  sb_entry_t             dec_entry;

  for (genvar s = 0; s < NSRC; s++) begin : g_src
    fu_src_match #(
      .NSTAGES (NSTAGES),
      .REG_W   (REG_W),
      .SEL_W   (SEL_W),
      .FWD_EN  (FWD_EN)
    ) u_match (
      .sb     (sb),
      .src    (src_reg[s*REG_W +: REG_W]),
      .ren    (src_ren[s]),
      .sel    (fwd_sel[s*SEL_W +: SEL_W]),
      .hazard (hazard_src[s])
    );
  end

  assign stall_dec = dec_valid & (|hazard_src);

  // A latency of 0 is treated as a single-cycle producer.
  always_comb begin
    dec_entry         = '0;
    dec_entry.valid   = 1'b1;
    dec_entry.wen     = dec_wen;
    dec_entry.dest    = dec_dest;
    dec_entry.rdy_cnt = (dec_lat == '0) ? '0 : dec_lat - 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 1; i <= NSTAGES; i++) sb[i] <= '0;
      stall_cycles <= '0;
    end else if (pipe_en) begin
      // Younger positions than FLUSH_N belong to squashed instructions.
      for (int i = NSTAGES; i >= 2; i--) begin
        if (flush && ((i - 1) < FLUSH_N)) sb[i] <= '0;
        else sb[i] <= sb_age(sb[i-1]);
      end
      if (dec_valid && !stall_dec && !flush) sb[1] <= dec_entry;
      else sb[1] <= '0;
      if (stall_dec && (stall_cycles != {CNT_W{1'b1}}))
        stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_scoreboard_forward_unit.sv
// tb/tb_scoreboard_forward_unit.sv - randomized scoreboard bench for scoreboard_forward_unit
module tb_scoreboard_forward_unit;
  import fu_pkg::*;

  localparam int NSTAGES = 3;
  localparam int CNT_MAX = 65535;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, pipe_en = 1'b1, flush = 1'b0, dec_valid = 1'b0, dec_wen = 1'b0;
  logic [4:0] dec_dest = '0;
  logic [1:0] dec_lat = '0;
  logic [9:0] src_reg = '0;
  logic [1:0] src_ren = '0;

  logic [3:0]  fwd_sel_a, fwd_sel_b;
  logic        stall_a, stall_b;
  logic [1:0]  hz_a, hz_b;
  logic [15:0] cnt_a, cnt_b;

  scoreboard_forward_unit #(.NSTAGES(3), .NSRC(2), .REG_W(5), .LAT_W(2), .FWD_EN(1),
                            .FLUSH_N(2), .CNT_W(16)) dut_a (
    .CLK(clk), .RST(rst), .pipe_en(pipe_en), .flush(flush), .dec_valid(dec_valid),
    .dec_wen(dec_wen), .dec_dest(dec_dest), .dec_lat(dec_lat), .src_reg(src_reg),
    .src_ren(src_ren), .fwd_sel(fwd_sel_a), .stall_dec(stall_a), .hazard_src(hz_a),
    .stall_cycles(cnt_a));

  scoreboard_forward_unit #(.NSTAGES(3), .NSRC(2), .REG_W(5), .LAT_W(2), .FWD_EN(0),
                            .FLUSH_N(1), .CNT_W(16)) dut_b (
    .CLK(clk), .RST(rst), .pipe_en(pipe_en), .flush(flush), .dec_valid(dec_valid),
    .dec_wen(dec_wen), .dec_dest(dec_dest), .dec_lat(dec_lat), .src_reg(src_reg),
    .src_ren(src_ren), .fwd_sel(fwd_sel_b), .stall_dec(stall_b), .hazard_src(hz_b),
    .stall_cycles(cnt_b));

  // Reference: list of in-flight instructions with their pipeline position.
  typedef struct { int pos; int dest; bit wen; int lat; } op_t;
  typedef op_t op_q_t[$];
  typedef struct { int sel0; int sel1; bit hz0; bit hz1; bit stall; int cnt; } exp_t;
  typedef struct { exp_t a; exp_t b; } exp_pair_t;

  exp_pair_t exp_q[$];
  op_q_t     qa, qb;
  int        ca = 0, cb = 0;
  bit        l_rst = 1'b1, l_pe = 1'b0, l_fl = 1'b0;
  bit        l_issue_a = 1'b0, l_issue_b = 1'b0, l_stall_a = 1'b0, l_stall_b = 1'b0;
  op_t       l_op;
  int        n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // A result becomes forwardable once the producer has travelled lat positions.
  function automatic exp_t model_eval(input op_q_t q, input bit fwd_en, input int cnt);
    exp_t e;
    int   srcs[2];
    bit   rens[2];
    int   sels[2];
    bit   hz[2];
    srcs[0] = int'(src_reg[4:0]);
    srcs[1] = int'(src_reg[9:5]);
    rens[0] = src_ren[0];
    rens[1] = src_ren[1];
    for (int s = 0; s < 2; s++) begin
      int best;
      best = -1;
      sels[s] = 0;
      hz[s] = 1'b0;
      for (int k = 0; k < q.size(); k++)
        if (rens[s] && srcs[s] != 0 && q[k].wen && q[k].dest == srcs[s] &&
            (best < 0 || q[k].pos < q[best].pos)) best = k;
      if (best >= 0) begin
        int lat_eff;
        lat_eff = (q[best].lat < 1) ? 1 : q[best].lat;
        if (fwd_en && q[best].pos >= lat_eff) sels[s] = q[best].pos;
        else hz[s] = 1'b1;
      end
    end
    e.sel0 = sels[0];
    e.sel1 = sels[1];
    e.hz0 = hz[0];
    e.hz1 = hz[1];
    e.stall = dec_valid && (hz[0] || hz[1]);
    e.cnt = cnt;
    return e;
  endfunction

  function automatic op_q_t model_advance(input op_q_t q, input bit fl, input int flush_n,
                                          input bit issue, input op_t nop);
    op_q_t r;
    foreach (q[k]) begin
      op_t o;
      o = q[k];
      if (!(fl && o.pos < flush_n)) begin
        o.pos++;
        if (o.pos <= NSTAGES) r.push_back(o);
      end
    end
    if (issue) r.push_back(nop);
    return r;
  endfunction

  task automatic apply_edge();
    if (l_rst) begin
      qa = {};
      qb = {};
      ca = 0;
      cb = 0;
    end else if (l_pe) begin
      qa = model_advance(qa, l_fl, 2, l_issue_a, l_op);
      qb = model_advance(qb, l_fl, 1, l_issue_b, l_op);
      if (l_stall_a && ca < CNT_MAX) ca++;
      if (l_stall_b && cb < CNT_MAX) cb++;
    end
  endtask

  task automatic step(input bit r, input bit pe, input bit fl, input bit dv, input bit dw,
                      input int dd, input int dl, input int s0, input int s1,
                      input bit r0, input bit r1);
    exp_pair_t ep;
    @(posedge clk);
    #1;
    apply_edge();
    rst = r; pipe_en = pe; flush = fl; dec_valid = dv; dec_wen = dw;
    dec_dest = 5'(dd); dec_lat = 2'(dl);
    src_reg = {5'(s1), 5'(s0)}; src_ren = {r1, r0};
    ep.a = model_eval(qa, 1'b1, ca);
    ep.b = model_eval(qb, 1'b0, cb);
    exp_q.push_back(ep);
    l_rst = r; l_pe = pe; l_fl = fl;
    l_op = '{pos: 1, dest: dd, wen: dw, lat: dl};
    l_issue_a = dv && !ep.a.stall && !fl;
    l_issue_b = dv && !ep.b.stall && !fl;
    l_stall_a = ep.a.stall;
    l_stall_b = ep.b.stall;
  endtask

  task automatic rst_cycle();
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_pair_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("a_sel0", int'(fwd_sel_a[1:0]), e.a.sel0);
        chk("a_sel1", int'(fwd_sel_a[3:2]), e.a.sel1);
        chk("a_hazard", int'(hz_a), int'({e.a.hz1, e.a.hz0}));
        chk("a_stall", int'(stall_a), int'(e.a.stall));
        chk("a_count", int'(cnt_a), e.a.cnt);
        chk("b_sel", int'(fwd_sel_b), (e.b.sel1 << 2) | e.b.sel0);
        chk("b_hazard", int'(hz_b), int'({e.b.hz1, e.b.hz0}));
        chk("b_stall", int'(stall_b), int'(e.b.stall));
        chk("b_count", int'(cnt_b), e.b.cnt);
      end
    end
  end

  initial begin : stimulus
    rst_cycle();
    rst_cycle();
    #1;
    chk("reset_stall", int'(stall_a), 0);
    chk("reset_count", int'(cnt_a), 0);

    // ALU chain: add r3 then sub r4,r3,r3
    step(0, 1, 0, 1, 1, 3, LAT_ALU, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 0, 1, 1, 4, LAT_ALU, 3, 3, 1, 1);
      #1;
      if (k == 0) begin
        chk("alu_fwd_sel", int'(fwd_sel_a), 4'b0101);
        chk("alu_no_stall", int'(stall_a), 0);
      end
      if (k < 3) chk("nofwd_stall", int'(stall_b), 1);
      else begin
        chk("nofwd_release", int'(stall_b), 0);
        chk("nofwd_sel", int'(fwd_sel_b), 0);
        chk("nofwd_count", int'(cnt_b), 3);
      end
    end

    // Load-use
    rst_cycle();
    step(0, 1, 0, 1, 1, 5, LAT_LOAD, 0, 0, 0, 0);
    step(0, 1, 0, 1, 1, 6, LAT_ALU, 5, 0, 1, 1);
    #1;
    chk("lu_stall", int'(stall_a), 1);
    chk("lu_hazard", int'(hz_a), 1);
    step(0, 1, 0, 1, 1, 6, LAT_ALU, 5, 0, 1, 1);
    #1;
    chk("lu_fwd_sel", int'(fwd_sel_a), 4'b0010);
    chk("lu_resolved", int'(stall_a), 0);
    chk("lu_count", int'(cnt_a), 1);

    // Freeze during load-use stall
    rst_cycle();
    step(0, 1, 0, 1, 1, 5, LAT_LOAD, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 1, 1, 6, LAT_ALU, 5, 0, 1, 1);
      #1;
      chk("frz_stall", int'(stall_a), 1);
      chk("frz_count", int'(cnt_a), 0);
    end
    step(0, 1, 0, 1, 1, 6, LAT_ALU, 5, 0, 1, 1);
    #1;
    chk("frz_resume_stall", int'(stall_a), 1);
    step(0, 1, 0, 1, 1, 6, LAT_ALU, 5, 0, 1, 1);
    #1;
    chk("frz_done_stall", int'(stall_a), 0);
    chk("frz_done_sel", int'(fwd_sel_a), 4'b0010);
    chk("frz_done_count", int'(cnt_a), 1);

    // Youngest wins, r0 never matches
    rst_cycle();
    step(0, 1, 0, 1, 1, 7, LAT_ALU, 0, 0, 0, 0);
    step(0, 1, 0, 1, 1, 0, LAT_ALU, 0, 0, 0, 0);
    step(0, 1, 0, 1, 1, 7, LAT_ALU, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, LAT_ALU, 7, 0, 1, 1);
    #1;
    chk("young_sel", int'(fwd_sel_a), 4'b0001);
    chk("young_stall", int'(stall_a), 0);

    // Flush with an r9 writer at position 1
    rst_cycle();
    step(0, 1, 0, 1, 1, 9, LAT_ALU, 0, 0, 0, 0);
    step(0, 1, 1, 1, 1, 10, LAT_ALU, 0, 0, 0, 0);
    step(0, 1, 0, 1, 1, 11, LAT_ALU, 9, 0, 1, 0);
    #1;
    chk("flush_sel", int'(fwd_sel_a), 0);
    chk("flush_stall", int'(stall_a), 0);
    chk("flush1_stall_b", int'(stall_b), 1);

    // Reset in the middle of a multi-cycle stall
    rst_cycle();
    step(0, 1, 0, 1, 1, 5, LAT_MUL, 0, 0, 0, 0);
    step(0, 1, 0, 1, 1, 6, LAT_ALU, 5, 0, 1, 0);
    step(1, 1, 0, 1, 1, 6, LAT_ALU, 5, 0, 1, 0);
    #1;
    chk("rst_pre_stall", int'(stall_a), 1);
    chk("rst_pre_count", int'(cnt_a), 1);
    step(0, 1, 0, 1, 1, 6, LAT_ALU, 5, 0, 1, 0);
    #1;
    chk("rst_post_stall", int'(stall_a), 0);
    chk("rst_post_count", int'(cnt_a), 0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 99) < 1, $urandom_range(0, 99) < 80, $urandom_range(0, 99) < 8,
           $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 75,
           int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    for (int n = 0; n < 4; n++) step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int n = 0; n < 10 && exp_q.size() > 0; n++) @(negedge clk);
    @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
